// File: rtl/net_pkg.sv
// Shared types for the transmit ping-pong buffer: bank/FSM state encodings and default bank depth.
package net_pkg;

  localparam int BANK_AW_DEF = 10;

  typedef enum logic [1:0] {
    BK_FREE    = 2'd0,
    BK_FILLING = 2'd1,
    BK_READY   = 2'd2,
    BK_SENDING = 2'd3
  } bank_st_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_SEND = 2'd2,
    TX_DONE = 2'd3
  } tx_st_t;

endpackage

// File: rtl/tx_bank_ram.sv
// Two-bank byte store, one write port and one registered read port; address MSB selects the bank.
// Read data appears the cycle after i_re; no backpressure, every strobe is honoured.
module tx_bank_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW:0]   i_waddr,
  input  logic [7:0]    i_wdat,
  input  logic          i_re,
  input  logic [AW:0]   i_raddr,
  output logic [7:0]    o_rdat
);

  logic [7:0] r_mem [0:(2<<AW)-1];
  logic [7:0] r_rdat;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
    if (i_re) begin
      r_rdat <= r_mem[i_raddr];
    end
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/net_tx_buf.sv
// Ping-pong transmit buffer: user bytes fill one bank while the network core drains the other.
// o_dat lags dat_tx_rden by one cycle; writes into a closed (READY/SENDING) bank are dropped with o_ovf.
module net_tx_buf
  import net_pkg::*;
#(
  parameter int BANK_AW = BANK_AW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_dat,
  input  logic        wr_last,
  output logic        o_full,
  output logic        o_ovf,
  output logic        o_dat_tx_req,
  output logic [15:0] o_dat_len,
  input  logic        dat_tx_rden,
  output logic [7:0]  o_dat,
  input  logic        dat_tx_end,
  output logic        o_busy
);

  localparam int LW = BANK_AW + 1;

  bank_st_t           r_bank_st [2];
  logic [LW-1:0]      r_len     [2];
  logic               r_wb;
  logic               r_rb;
  logic [BANK_AW-1:0] r_wptr;
  logic [LW-1:0]      r_rptr;
  tx_st_t             r_tx_st;
  tx_st_t             w_tx_nxt;
  logic [15:0]        r_dat_len;
  logic               r_ovf;
  logic               r_rd_vld;
  logic [7:0]         r_dat_hold;

  logic               w_wr_open;
  logic               w_wr_ok;
  logic               w_close;
  logic               w_tx_act;
  logic               w_start;
  logic               w_done;
  logic               w_rd_more;
  logic               w_rd_fire;
  logic               w_zero_fire;
  logic [7:0]         w_ram_q;

  // ---------------- write side ----------------
  assign w_wr_open = (r_bank_st[r_wb] == BK_FREE) || (r_bank_st[r_wb] == BK_FILLING);
  assign o_full    = !w_wr_open;
  assign w_wr_ok   = wr_en && w_wr_open;
  assign w_close   = w_wr_ok && (wr_last || (r_wptr == '1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_wb   <= 1'b0;
      r_ovf  <= 1'b0;
      r_len[0] <= '0;
      r_len[1] <= '0;
    end else begin
      r_ovf <= wr_en && o_full;
      if (w_close) begin
        r_len[r_wb] <= LW'(r_wptr) + LW'(1);
        r_wptr      <= '0;
        r_wb        <= ~r_wb;
      end else if (w_wr_ok) begin
        r_wptr <= r_wptr + BANK_AW'(1);
      end
    end
  end

  assign o_ovf = r_ovf;

  // Writer only touches FREE/FILLING banks and the FSM only READY/SENDING ones,
  // so a close and a release in the same cycle always hit different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_st[0] <= BK_FREE;
      r_bank_st[1] <= BK_FREE;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_wr_ok && (r_wb == b[0])) begin
          r_bank_st[b] <= w_close ? BK_READY : BK_FILLING;
        end
        if (w_start && (r_rb == b[0])) begin
          r_bank_st[b] <= BK_SENDING;
        end
        if (w_done && (r_rb == b[0])) begin
          r_bank_st[b] <= BK_FREE;
        end
      end
    end
  end

  // ---------------- transmit FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st <= TX_IDLE;
    end else begin
      r_tx_st <= w_tx_nxt;
    end
  end

  always_comb begin
    w_tx_nxt = r_tx_st;
    case (r_tx_st)
      TX_IDLE: if (r_bank_st[r_rb] == BK_READY) w_tx_nxt = TX_REQ;
      TX_REQ: begin
        if (dat_tx_end)       w_tx_nxt = TX_DONE;
        else if (dat_tx_rden) w_tx_nxt = TX_SEND;
      end
      TX_SEND: if (dat_tx_end) w_tx_nxt = TX_DONE;
      TX_DONE: w_tx_nxt = TX_IDLE;
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_act     = (r_tx_st == TX_REQ) || (r_tx_st == TX_SEND);
    w_start      = (r_tx_st == TX_IDLE) && (r_bank_st[r_rb] == BK_READY);
    w_done       = (r_tx_st == TX_DONE);
    o_dat_tx_req = w_tx_act && !dat_tx_end;
    o_busy       = (r_tx_st != TX_IDLE);
  end

  // ---------------- read side ----------------
  assign w_rd_more   = (r_rptr != r_len[r_rb]);
  assign w_rd_fire   = w_tx_act && dat_tx_rden && w_rd_more;
  assign w_zero_fire = w_tx_act && dat_tx_rden && !w_rd_more;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb       <= 1'b0;
      r_rptr     <= '0;
      r_dat_len  <= '0;
      r_rd_vld   <= 1'b0;
      r_dat_hold <= '0;
    end else begin
      r_rd_vld <= w_rd_fire;
      if (w_start) begin
        r_dat_len <= 16'(r_len[r_rb]);
      end
      if (w_rd_fire) begin
        r_rptr <= r_rptr + LW'(1);
      end
      if (w_done) begin
        r_rptr <= '0;
        r_rb   <= ~r_rb;
      end
      if (w_zero_fire) begin
        r_dat_hold <= 8'h00;
      end else if (r_rd_vld) begin
        r_dat_hold <= w_ram_q;
      end
    end
  end

  // RAM output is unreset, so the held copy covers reset and idle cycles.
  assign o_dat     = r_rd_vld ? w_ram_q : r_dat_hold;
  assign o_dat_len = r_dat_len;

  tx_bank_ram #(
    .AW (BANK_AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr ({r_wb, r_wptr}),
    .i_wdat  (wr_dat),
    .i_re    (w_rd_fire),
    .i_raddr ({r_rb, r_rptr[BANK_AW-1:0]}),
    .o_rdat  (w_ram_q)
  );

endmodule

// File: tb/tb_net_tx_buf.sv
// Directed bench for net_tx_buf: single packet, ping-pong, overflow, auto-close, over-read, reset in SEND.
module tb_net_tx_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_dat;
  logic        wr_last;
  logic        o_full;
  logic        o_ovf;
  logic        o_dat_tx_req;
  logic [15:0] o_dat_len;
  logic        dat_tx_rden;
  logic [7:0]  o_dat;
  logic        dat_tx_end;
  logic        o_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  net_tx_buf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_dat       (wr_dat),
    .wr_last      (wr_last),
    .o_full       (o_full),
    .o_ovf        (o_ovf),
    .o_dat_tx_req (o_dat_tx_req),
    .o_dat_len    (o_dat_len),
    .dat_tx_rden  (dat_tx_rden),
    .o_dat        (o_dat),
    .dat_tx_end   (dat_tx_end),
    .o_busy       (o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic last);
    wr_en   = 1'b1;
    wr_dat  = d;
    wr_last = last;
    step();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] exp);
    dat_tx_rden = 1'b1;
    step();
    dat_tx_rden = 1'b0;
    chk(tag, {24'h0, o_dat}, {24'h0, exp});
  endtask

  // Pulses dat_tx_end; request must drop in the same cycle.
  task automatic end_pkt(input string tag);
    dat_tx_end = 1'b1;
    #1;
    chk(tag, {31'h0, o_dat_tx_req}, 32'h0);
    step();
    dat_tx_end = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    wr_en       = 1'b0;
    wr_dat      = 8'h00;
    wr_last     = 1'b0;
    dat_tx_rden = 1'b0;
    dat_tx_end  = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_req",  {31'h0, o_dat_tx_req}, 32'h0);
    chk("rst_len",  {16'h0, o_dat_len},    32'h0);
    chk("rst_dat",  {24'h0, o_dat},        32'h0);
    chk("rst_ovf",  {31'h0, o_ovf},        32'h0);
    chk("rst_busy", {31'h0, o_busy},       32'h0);
    chk("rst_full", {31'h0, o_full},       32'h0);
    rst_n = 1'b1;
    step();

    // Single packet 11,22,33
    wr_byte(8'h11, 1'b0);
    wr_byte(8'h22, 1'b0);
    wr_byte(8'h33, 1'b1);
    chk("sp_req_pre", {31'h0, o_dat_tx_req}, 32'h0);
    step();
    chk("sp_req",  {31'h0, o_dat_tx_req}, 32'h1);
    chk("sp_len",  {16'h0, o_dat_len},    32'd3);
    chk("sp_busy", {31'h0, o_busy},       32'h1);
    rd_byte("sp_d0", 8'h11);
    rd_byte("sp_d1", 8'h22);
    rd_byte("sp_d2", 8'h33);
    end_pkt("sp_end_req");
    chk("sp_busy_done", {31'h0, o_busy}, 32'h1);
    step();
    chk("sp_busy_idle", {31'h0, o_busy}, 32'h0);
    chk("sp_req_idle",  {31'h0, o_dat_tx_req}, 32'h0);

    // Ping-pong: 5-byte packet, 7-byte packet written while the first drains
    for (int i = 0; i < 5; i++) wr_byte(8'hA0 + 8'(i), (i == 4));
    step();
    chk("pp_len1", {16'h0, o_dat_len}, 32'd5);
    for (int i = 0; i < 7; i++) begin
      wr_en       = 1'b1;
      wr_dat      = 8'hB0 + 8'(i);
      wr_last     = (i == 6);
      dat_tx_rden = (i < 5);
      step();
      wr_en       = 1'b0;
      wr_last     = 1'b0;
      dat_tx_rden = 1'b0;
      if (i < 5) chk("pp_d1", {24'h0, o_dat}, {24'h0, 8'hA0 + 8'(i)});
    end
    chk("pp_full", {31'h0, o_full}, 32'h1);
    end_pkt("pp_end_req");
    chk("pp_gap0", {31'h0, o_dat_tx_req}, 32'h0);
    step();
    chk("pp_gap1", {31'h0, o_dat_tx_req}, 32'h0);
    step();
    chk("pp_req2", {31'h0, o_dat_tx_req}, 32'h1);
    chk("pp_len2", {16'h0, o_dat_len},    32'd7);
    for (int i = 0; i < 7; i++) rd_byte("pp_d2", 8'hB0 + 8'(i));
    end_pkt("pp_end2_req");
    step();
    chk("pp_busy_idle", {31'h0, o_busy}, 32'h0);

    // Full / overflow: both banks closed, no reads yet
    wr_byte(8'hC1, 1'b0);
    wr_byte(8'hC2, 1'b1);
    wr_byte(8'hD1, 1'b1);
    chk("ov_full", {31'h0, o_full}, 32'h1);
    chk("ov_ovf_pre", {31'h0, o_ovf}, 32'h0);
    wr_byte(8'hEE, 1'b1);
    chk("ov_ovf", {31'h0, o_ovf}, 32'h1);
    step();
    chk("ov_ovf_clr", {31'h0, o_ovf}, 32'h0);
    chk("ov_len1", {16'h0, o_dat_len}, 32'd2);
    rd_byte("ov_c1", 8'hC1);
    rd_byte("ov_c2", 8'hC2);
    end_pkt("ov_end1_req");
    step();
    step();
    chk("ov_len2", {16'h0, o_dat_len}, 32'd1);
    rd_byte("ov_d1", 8'hD1);
    rd_byte("ov_no_ee", 8'h00);
    end_pkt("ov_end2_req");
    step();

    // Auto-close at full bank depth
    for (int i = 0; i < 1024; i++) wr_byte(8'(i) ^ 8'h5A, 1'b0);
    chk("ac_full_after_close", {31'h0, o_full}, 32'h0);
    wr_byte(8'h77, 1'b1);
    chk("ac_req", {31'h0, o_dat_tx_req}, 32'h1);
    chk("ac_len", {16'h0, o_dat_len},    32'd1024);
    rd_byte("ac_d0", 8'h5A);
    rd_byte("ac_d1", 8'h5B);
    end_pkt("ac_end1_req");
    step();
    step();
    chk("ac_len_next", {16'h0, o_dat_len}, 32'd1);
    rd_byte("ac_next_d0", 8'h77);
    end_pkt("ac_end2_req");
    step();

    // Over-read: 2-byte packet, extra reads return zero
    wr_byte(8'h5C, 1'b0);
    wr_byte(8'h5D, 1'b1);
    step();
    chk("or_len", {16'h0, o_dat_len}, 32'd2);
    rd_byte("or_d0", 8'h5C);
    rd_byte("or_d1", 8'h5D);
    rd_byte("or_d2", 8'h00);
    rd_byte("or_d3", 8'h00);
    chk("or_rptr", {21'h0, dut.r_rptr}, 32'd2);
    end_pkt("or_end_req");
    step();

    // Reset while in SEND, with a partial packet pending in the other bank
    wr_byte(8'h61, 1'b0);
    wr_byte(8'h62, 1'b1);
    step();
    rd_byte("rs_d0", 8'h61);
    wr_byte(8'h63, 1'b0);
    chk("rs_busy_pre", {31'h0, o_busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_req",  {31'h0, o_dat_tx_req}, 32'h0);
    chk("rs_len",  {16'h0, o_dat_len},    32'h0);
    chk("rs_dat",  {24'h0, o_dat},        32'h0);
    chk("rs_busy", {31'h0, o_busy},       32'h0);
    chk("rs_full", {31'h0, o_full},       32'h0);
    chk("rs_ovf",  {31'h0, o_ovf},        32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rs_no_req", {31'h0, o_dat_tx_req}, 32'h0);
    end
    wr_byte(8'h99, 1'b1);
    step();
    chk("rs_new_req", {31'h0, o_dat_tx_req}, 32'h1);
    chk("rs_new_len", {16'h0, o_dat_len},    32'd1);
    rd_byte("rs_new_d0", 8'h99);
    end_pkt("rs_end_req");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
